instruction_fetch: RTL and testbench
====================================

# instruction_fetch

- Fetch front end of the Neko-V core.
- Consumes the address driven by the program counter.
- Issues instruction-memory reads over a valid/ready handshake and holds responses in a small in-order buffer.
- Presents {instruction, pc} pairs to decode, and advances the PC through its count-enable input.
- Branch/jump redirects flush the buffer and discard stale in-flight responses.

## Interface
- XLEN, 32, address/instruction width
- DEPTH, 4, buffer entries (power of two, ≥2); bounds issued-but-not-consumed fetches
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- pcIn  in  XLEN  current PC (program counter dataOut)
- pcCountEnable  out  XLEN-independent 1  drives program counter countEnable; PC += 4 on next edge
- redirect  in  1  PC is being written (jump/branch) this cycle; flush
- memReqValid  out  1  fetch request valid
- memReqAddr  out  XLEN  fetch address
- memReqReady  in  1  memory accepts request
- memRspValid  in  1  response data valid (in request order, ≥1 cycle after acceptance)
- memRspData  in  XLEN  instruction word
- instValid  out  1  head entry filled
- instData  out  XLEN  head instruction
- instPc  out  XLEN  address of head instruction
- instReady  in  1  decode consumes head

## Operation
- Buffer entry = {pc, data, filled}.
  - Three pointers of log2(DEPTH)+1 bits: tail (allocate at issue), fill (response write), head (pop).
- Issue condition: state RUN, !redirect, (tail−head) < DEPTH.
  - memReqValid = issue condition.
  - memReqAddr = pcIn.
- Handshake:
  - On memReqValid && memReqReady: entry[tail].pc ← pcIn, filled ← 0, tail++.
  - pcCountEnable = memReqValid && memReqReady (combinational).
  - memReqValid may drop without acceptance; no stickiness is required.
- Response in RUN: entry[fill].data ← memRspData, filled ← 1, fill++.
  - memRspValid with fill==tail is a protocol error; ignore it.
- Pop: instValid = (head≠fill).
  - On instValid && instReady, head++.
  - instData/instPc come from entry[head]; they are 0 when !instValid.
- Redirect:
  - head, fill ← tail.
  - discard ← tail−fill (outstanding count), minus 1 if memRspValid is asserted in the same cycle.
  - Go to DRAIN if the result is >0, else stay RUN.
  - A pop and a response in the redirect cycle are both dropped.
- States:
  - RUN: normal operation.
  - DRAIN: no issue; each memRspValid decrements discard; at 0 → RUN. A redirect in DRAIN keeps DRAIN; discard is unchanged because nothing new was issued.
  - FAULT: only present with the macro (see Configuration).
- Wrap-around: pointers wrap naturally; full = MSBs differ with equal low bits; empty = equal.

## Timing
- Reset values: all pointers 0, discard 0, state RUN.
  - memReqValid=1 (issues from pcIn in the first cycle after reset deasserts).
  - instValid=0, instData=0, instPc=0, pcCountEnable follows memReqReady.
- Reset mid-operation: everything is flushed on that edge; memory is reset together, so no stale responses are expected.
- Latency:
  - Request to memory: 0 cycles from pcIn.
  - Response to instValid: 1 cycle (registered fill).
  - Redirect: first new request the cycle after DRAIN ends, or the next cycle if nothing was outstanding.
- Throughput: one fetch per cycle with single-cycle memory and instReady held high.

## Configuration
- FETCH_MISALIGN_TRAP_EN
- Defined:
  - pcIn[1:0]≠0 at an issue opportunity suppresses memReqValid and pcCountEnable.
  - Enters FAULT after already-buffered entries are popped.
  - instFault (out, 1, reset 0) asserts with instPc=faulting pc, instData=0, until redirect.
- Undefined:
  - No check; low bits pass through to memReqAddr.
  - No instFault port, no FAULT state.

## Structure
- Shared package `nekov_pkg`: XLEN, fetch state enum {RUN, DRAIN, FAULT}, instruction-entry struct {pc, data, filled}.
- One sub-module, `fetch_buffer`: pointer/entry storage with alloc/fill/pop/flush ports.
- FSM, discard counter and handshake logic stay in instruction_fetch.

## Test plan
- Reset with pcIn=0, memReqReady=1, 1-cycle memory, instReady=1:
  - pcCountEnable high every cycle.
  - instPc sequence 0,4,8,… with matching memRspData.
- instReady=0, DEPTH=4, memory always ready:
  - Exactly 4 acceptances.
  - memReqValid=0 afterward; pcIn is not advanced.
  - Popping one entry restores a single issue.
- Memory with 3-cycle latency, 2 outstanding, redirect to 0xDEADBEEC:
  - Next 2 responses are discarded.
  - First delivered instPc = 0xDEADBEEC.
- Redirect asserted in the same cycle as memRspValid and instValid&&instReady:
  - Both are dropped.
  - discard equals outstanding−1.
  - No stale instValid.
- Fill to full, pop and issue in the same cycle across the pointer wrap (≥2×DEPTH fetches): no lost or duplicated instPc.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x6:
  - No request issued.
  - instFault=1, instPc=0x6.
  - Redirect to 0x8 clears the fault and resumes fetch.

Source files
------------

// File: rtl/nekov_pkg.sv
// Shared types for the Neko-V fetch front end: data width, fetch FSM states, buffer entry.
// No logic; constants and typedefs only.
// Consumed by instruction_fetch and fetch_buffer.
package nekov_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic            filled;
    } inst_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: alloc at tail on issue, fill on response, pop at head; flush drops all.
// Latency: a fill is visible at head_o the cycle after it is written.
// Backpressure: full_o when DEPTH entries are allocated but not yet popped.
module fetch_buffer
    import nekov_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc_i,
    input  logic [XLEN-1:0]             alloc_pc_i,
    input  logic                        fill_i,
    input  logic [XLEN-1:0]             fill_data_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    output logic                        full_o,
    output logic [$clog2(DEPTH):0]      outstanding_o,
    output logic                        head_vld_o,
    output inst_entry_t                 head_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] PONE = PW'(1);

    logic [PW-1:0] head_q, fill_q, tail_q;
    logic [PW-1:0] head_d, fill_d, tail_d;
    inst_entry_t   mem_q [DEPTH];

    // Pointer next state; a flush collapses head and fill onto tail so stale entries vanish.
    always_comb begin
        head_d = head_q;
        fill_d = fill_q;
        tail_d = tail_q;
        if (flush_i) begin
            head_d = tail_q;
            fill_d = tail_q;
        end else begin
            if (alloc_i) tail_d = tail_q + PONE;
            if (fill_i)  fill_d = fill_q + PONE;
            if (pop_i)   head_d = head_q + PONE;
        end
    end

    // Pointer registers and entry storage; alloc and fill never target the same slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q <= head_d;
            fill_q <= fill_d;
            tail_q <= tail_d;
            if (!flush_i) begin
                if (alloc_i) begin
                    mem_q[tail_q[IW-1:0]].pc     <= alloc_pc_i;
                    mem_q[tail_q[IW-1:0]].data   <= '0;
                    mem_q[tail_q[IW-1:0]].filled <= 1'b0;
                end
                if (fill_i) begin
                    mem_q[fill_q[IW-1:0]].data   <= fill_data_i;
                    mem_q[fill_q[IW-1:0]].filled <= 1'b1;
                end
            end
        end
    end

    // Full when the pointers alias the same slot on opposite laps.
    assign full_o        = (tail_q[PW-1] != head_q[PW-1]) && (tail_q[IW-1:0] == head_q[IW-1:0]);
    assign outstanding_o = tail_q - fill_q;
    assign head_vld_o    = (head_q != fill_q);
    assign head_o        = head_vld_o ? mem_q[head_q[IW-1:0]] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: issues PC-addressed reads, buffers responses in order, hands {inst,pc} to decode.
// Latency: request is combinational from pcIn; response reaches instValid one cycle later.
// Backpressure: stops issuing while DEPTH fetches are unconsumed; optional FETCH_MISALIGN_TRAP_EN adds a misaligned-PC fault.
module instruction_fetch
    import nekov_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pcIn,
    output logic            pcCountEnable,
    input  logic            redirect,
    output logic            memReqValid,
    output logic [XLEN-1:0] memReqAddr,
    input  logic            memReqReady,
    input  logic            memRspValid,
    input  logic [XLEN-1:0] memRspData,
    output logic            instValid,
    output logic [XLEN-1:0] instData,
    output logic [XLEN-1:0] instPc,
    input  logic            instReady
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            instFault
`endif
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] PONE = PW'(1);

    fetch_state_e  state_q;
    logic [PW-1:0] discard_q;
    logic [PW-1:0] outstanding;
    logic [PW-1:0] redir_discard;
    logic          buf_full, head_vld, issue_ok, accept, rsp_fill, pop, rsp_early;
    inst_entry_t   head_entry;

    assign issue_ok = (state_q == ST_RUN) && !redirect && !buf_full;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign, buf_empty;
    logic [XLEN-1:0] fault_pc_q;
    assign misalign    = (pcIn[1:0] != 2'b00);
    assign buf_empty   = !head_vld && (outstanding == '0);
    assign memReqValid = issue_ok && !misalign;
    assign instFault   = (state_q == ST_FAULT);
    assign instPc      = instFault ? fault_pc_q : head_entry.pc;
`else
    assign memReqValid = issue_ok;
    assign instPc      = head_entry.pc;
`endif

    assign memReqAddr    = pcIn;
    assign accept        = memReqValid && memReqReady;
    assign pcCountEnable = accept;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fill      = (state_q == ST_RUN) && !redirect && memRspValid && (outstanding != '0);
    assign instValid     = head_vld && head_entry.filled;
    assign instData      = head_entry.data;
    assign pop           = instValid && instReady && !redirect;

    // A response landing in the redirect cycle already retires one of the stale fetches.
    assign rsp_early     = memRspValid && (outstanding != '0);
    assign redir_discard = rsp_early ? (outstanding - PONE) : outstanding;

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk          (clk),
        .reset        (reset),
        .alloc_i      (accept),
        .alloc_pc_i   (pcIn),
        .fill_i       (rsp_fill),
        .fill_data_i  (memRspData),
        .pop_i        (pop),
        .flush_i      (redirect),
        .full_o       (buf_full),
        .outstanding_o(outstanding),
        .head_vld_o   (head_vld),
        .head_o       (head_entry)
    );

    // Fetch FSM: RUN issues, DRAIN swallows stale responses after a redirect, FAULT parks on a misaligned PC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            discard_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_pc_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (redirect) begin
                        discard_q <= redir_discard;
                        state_q   <= (redir_discard != '0) ? ST_DRAIN : ST_RUN;
                    end
`ifdef FETCH_MISALIGN_TRAP_EN
                    else if (misalign && buf_empty) begin
                        state_q    <= ST_FAULT;
                        fault_pc_q <= pcIn;
                    end
`endif
                end
                ST_DRAIN: begin
                    // A redirect here issues nothing new, so only stale responses move the count.
                    if (memRspValid) begin
                        if (discard_q <= PONE) begin
                            discard_q <= '0;
                            state_q   <= ST_RUN;
                        end else begin
                            discard_q <= discard_q - PONE;
                        end
                    end
                end
                ST_FAULT: begin
                    if (redirect) state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import nekov_pkg::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pcIn;
    logic            pcCountEnable;
    logic            redirect;
    logic            memReqValid;
    logic [XLEN-1:0] memReqAddr;
    logic            memReqReady;
    logic            memRspValid;
    logic [XLEN-1:0] memRspData;
    logic            instValid;
    logic [XLEN-1:0] instData;
    logic [XLEN-1:0] instPc;
    logic            instReady;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            instFault;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .pcIn         (pcIn),
        .pcCountEnable(pcCountEnable),
        .redirect     (redirect),
        .memReqValid  (memReqValid),
        .memReqAddr   (memReqAddr),
        .memReqReady  (memReqReady),
        .memRspValid  (memRspValid),
        .memRspData   (memRspData),
        .instValid    (instValid),
        .instData     (instData),
        .instPc       (instPc),
        .instReady    (instReady)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .instFault    (instFault)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Memory model and scoreboard state
    typedef struct {
        logic [31:0] data;
        int          due;
    } mem_t;

    mem_t        mem_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] pc_m;
    int          cyc = 0;
    int          lat = 1;
    int          acc_cnt;
    int          pop_cnt;
    logic [31:0] first_pop;
    logic        o_req, o_vld, o_pce;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: entered just after a negedge, returns just after the next negedge.
    task automatic step(input logic rdy, input logic irdy, input logic redir, input logic [31:0] tgt);
        logic [31:0] e;
        int          occ;
        memReqReady = rdy;
        instReady   = irdy;
        redirect    = redir;
        memRspValid = 1'b0;
        memRspData  = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            memRspValid = 1'b1;
            memRspData  = mem_q[0].data;
        end
        #1;
        occ   = exp_q.size();
        o_req = memReqValid;
        o_vld = instValid;
        o_pce = pcCountEnable;
        if (memReqValid) check_val("req_addr", memReqAddr, pc_m);
        check_val("pc_cnt_en", {31'b0, pcCountEnable}, {31'b0, memReqValid & rdy});
        if (!instValid) check_val("idle_data", instData, 32'h0);
        if (instValid && irdy && !redir) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_inst", {31'b0, instValid}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check_val("inst_pc", instPc, e);
                check_val("inst_data", instData, mem_word(e));
                if (pop_cnt == 0) first_pop = instPc;
                pop_cnt++;
            end
        end
        if (memReqValid && rdy) begin
            check_val("occupancy", {31'b0, occ < DEPTH}, 32'h1);
            exp_q.push_back(pc_m);
            mem_q.push_back('{data: mem_word(pc_m), due: cyc + lat});
            acc_cnt++;
        end
        if (memRspValid) void'(mem_q.pop_front());
        if (redir) exp_q.delete();
        @(posedge clk);
        cyc++;
        if (redir) pc_m = tgt;
        else if (o_pce) pc_m = pc_m + 32'd4;
        @(negedge clk);
        pcIn = pc_m;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        memReqReady = 1'b1;
        instReady   = 1'b0;
        redirect    = 1'b0;
        memRspValid = 1'b0;
        memRspData  = '0;
        pc_m        = '0;
        pcIn        = '0;
        mem_q.delete();
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        check_val("rst_req_vld", {31'b0, memReqValid}, 32'h1);
        check_val("rst_inst_vld", {31'b0, instValid}, 32'h0);
        check_val("rst_inst_data", instData, 32'h0);
        check_val("rst_inst_pc", instPc, 32'h0);
        check_val("rst_pce_rdy", {31'b0, pcCountEnable}, 32'h1);
        memReqReady = 1'b0;
        #1;
        check_val("rst_pce_nordy", {31'b0, pcCountEnable}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_val("rst_fault", {31'b0, instFault}, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Full-rate streaming with single-cycle memory
        lat = 1; pop_cnt = 0; acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            check_val("t1_pce", {31'b0, o_pce}, 32'h1);
        end
        check_val("t1_pops", pop_cnt, 18);
        check_val("t1_first_pc", first_pop, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check_val("t1_drained", exp_q.size(), 0);

        // Decode stalled: buffer caps outstanding fetches at DEPTH
        acc_cnt = 0;
        begin
            logic [31:0] pc_start;
            pc_start = pc_m;
            for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
            check_val("t2_accepts", acc_cnt, DEPTH);
            check_val("t2_req_low", {31'b0, o_req}, 32'h0);
            check_val("t2_pc_held", pc_m, pc_start + 32'd16);
        end
        acc_cnt = 0;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("t2_one_more", acc_cnt, 1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check_val("t2_drained", exp_q.size(), 0);

        // Redirect with two fetches in flight on a 3-cycle memory
        do_reset();
        reset = 1'b1;
        lat = 3; pop_cnt = 0;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("t3_drain1", {31'b0, o_req}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("t3_drain2", {31'b0, o_req}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("t3_resume", {31'b0, o_req}, 32'h1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("t3_first_pc", first_pop, 32'hDEAD_BEEC);
        check_val("t3_delivered", {31'b0, pop_cnt > 0}, 32'h1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect coinciding with a response and a pop
        do_reset();
        reset = 1'b1;
        lat = 2; pop_cnt = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        pop_cnt = 0;
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        check_val("t4_vld_at_redir", {31'b0, o_vld}, 32'h1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("t4_drain_noreq", {31'b0, o_req}, 32'h0);
        check_val("t4_no_stale", {31'b0, o_vld}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("t4_resume", {31'b0, o_req}, 32'h1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("t4_first_pc", first_pop, 32'h0000_0100);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

        // Fill to full, then pop+issue across pointer wrap, then random traffic
        do_reset();
        reset = 1'b1;
        lat = 1; acc_cnt = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6), 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check_val("t5_drained", exp_q.size(), 0);
        check_val("t5_wrapped", {31'b0, acc_cnt >= 2 * DEPTH}, 32'h1);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect target traps until the next redirect
        pop_cnt = 0;
        step(1'b1, 1'b1, 1'b1, 32'h0000_0006);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("t6_no_req", {31'b0, o_req}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("t6_fault", {31'b0, instFault}, 32'h1);
        check_val("t6_fault_pc", instPc, 32'h0000_0006);
        check_val("t6_fault_data", instData, 32'h0);
        check_val("t6_fault_noreq", {31'b0, memReqValid}, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0008);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("t6_resume", {31'b0, o_req}, 32'h1);
        check_val("t6_fault_clr", {31'b0, instFault}, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("t6_first_pc", first_pop, 32'h0000_0008);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
